// File: rtl/onehot_strobe_pkg.sv
// Shared types and sizing helpers for the one-hot strobe decoder.
package onehot_strobe_pkg;

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam int HOLD_MAX = 255;

  // Smallest width (at least 1) whose range covers value distinct codes.
  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/onehot_strobe_decoder_if.sv
// Index handshake bundle: the source drives in_valid/A/en, the decoder answers with in_ready.
interface onehot_strobe_decoder_if #(
  parameter int N = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic         en;

  modport master (output in_valid, A, en, input in_ready);
  modport slave  (input in_valid, A, en, output in_ready);
endinterface

// File: rtl/onehot_decoder_comb.sv
// Combinational N-to-2**N one-hot decoder with enable; all-zero output when en is low.
module onehot_decoder_comb #(
  parameter int N = 3
) (
  input  logic [N-1:0]    A,
  input  logic            en,
  output logic [2**N-1:0] Y
);

  always_comb begin
    Y = '0;
    if (en) Y[A] = 1'b1;
  end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Drives a registered one-hot strobe for HOLD cycles per accepted index; done pulses in the last cycle.
// ONEHOT_STROBE_SKID_EN adds a one-entry buffer so back-to-back strobes run seamlessly.
module onehot_strobe_decoder
  import onehot_strobe_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  onehot_strobe_decoder_if.slave   in_if,
  output logic [2**N-1:0]          Y,
  output logic                     busy,
  output logic                     done
);

  if (HOLD < 1 || HOLD > HOLD_MAX) begin : g_bad_hold
    $error("onehot_strobe_decoder: HOLD out of range");
  end

  localparam int            CW       = clog2_w(HOLD + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic            take;
  logic            start;
  logic [N-1:0]    dec_a;
  logic            dec_en;
  logic [2**N-1:0] dec_y;

  assign take = in_if.in_valid && in_if.in_ready;

`ifdef ONEHOT_STROBE_SKID_EN
  logic [N-1:0] a_b;
  logic         en_b;
  logic         full_b;
  logic         last;
  logic         use_buf;

  assign last    = (state == DRIVE) && (count == '0);
  assign use_buf = last && full_b;
  assign in_if.in_ready = (state == IDLE) || !full_b;
  // A buffered index wins the final cycle; otherwise a fresh index may start directly.
  assign start  = (state == IDLE) ? take : (last && (full_b || take));
  assign dec_a  = use_buf ? a_b  : in_if.A;
  assign dec_en = use_buf ? en_b : in_if.en;
`else
  assign in_if.in_ready = (state == IDLE);
  assign start  = take;
  assign dec_a  = in_if.A;
  assign dec_en = in_if.en;
`endif

  onehot_decoder_comb #(.N(N)) u_dec (
    .A  (dec_a),
    .en (dec_en),
    .Y  (dec_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      Y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ONEHOT_STROBE_SKID_EN
      a_b    <= '0;
      en_b   <= 1'b0;
      full_b <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= DRIVE;
            count <= CNT_LOAD;
            Y     <= dec_y;
            busy  <= 1'b1;
            done  <= (CNT_LOAD == '0);
          end else begin
            done <= 1'b0;
          end
        end
        DRIVE: begin
          if (count == '0) begin
            if (start) begin
              count <= CNT_LOAD;
              Y     <= dec_y;
              done  <= (CNT_LOAD == '0);
            end else begin
              state <= IDLE;
              Y     <= '0;
              busy  <= 1'b0;
              done  <= 1'b0;
            end
          end else begin
            count <= count - CW'(1);
            done  <= (count == CW'(1));
          end
        end
        default: begin
          state <= IDLE;
          Y     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
`ifdef ONEHOT_STROBE_SKID_EN
      if (take && state == DRIVE && !last) begin
        a_b    <= in_if.A;
        en_b   <= in_if.en;
        full_b <= 1'b1;
      end else if (use_buf) begin
        full_b <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder: vector table, corner sequences and a randomized run against a schedule model.
module tb_onehot_strobe_decoder;

`ifdef ONEHOT_STROBE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int HOLD0 = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  onehot_strobe_decoder_if #(.N(3)) i0 ();
  onehot_strobe_decoder_if #(.N(3)) i1 ();
  onehot_strobe_decoder_if #(.N(2)) i2 ();

  logic [7:0] y0, y1;
  logic [3:0] y2;
  logic busy0, busy1, busy2, done0, done1, done2;

  onehot_strobe_decoder #(.N(3), .HOLD(HOLD0)) d0 (
    .clk(clk), .reset(reset), .in_if(i0), .Y(y0), .busy(busy0), .done(done0));
  onehot_strobe_decoder #(.N(3), .HOLD(3)) d1 (
    .clk(clk), .reset(reset), .in_if(i1), .Y(y1), .busy(busy1), .done(done1));
  onehot_strobe_decoder #(.N(2), .HOLD(1)) d2 (
    .clk(clk), .reset(reset), .in_if(i2), .Y(y2), .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every output must be one-hot or zero on every cycle.
  always @(negedge clk) begin
    chk("never_multihot", {31'd0, $onehot0(y0) && $onehot0(y1) && $onehot0(y2)}, 32'd1);
  end

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic       en;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic [2:0] a, input logic en,
                              input logic [7:0] y, input logic busy, input logic done,
                              input logic rdy);
    vec_t r;
    r.v = v; r.a = a; r.en = en; r.y = y; r.busy = busy; r.done = done; r.rdy = rdy;
    tbl.push_back(r);
  endfunction

  typedef struct {
    int         s;
    int         e;
    logic [7:0] y;
  } strobe_t;
  strobe_t sched[$];

  initial begin
    int c, last_end, last_start, s;
    logic [7:0] ey, one;
    logic eb, ed, er;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    i0.in_valid = 0; i0.A = '0; i0.en = 0;
    i1.in_valid = 0; i1.A = '0; i1.en = 0;
    i2.in_valid = 0; i2.A = '0; i2.en = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", {24'd0, y0}, 0);
    chk("reset_busy_done", {30'd0, busy0, done0}, 0);
    reset = 1'b0;

    // Single strobe of A=5, then throughput / back-to-back behaviour.
    add(1, 3'd5, 1, 8'h00, 0, 0, 1);
    add(0, 3'd0, 0, 8'h20, 1, 0, SKID);
    add(0, 3'd0, 0, 8'h20, 1, 1, SKID);
    add(0, 3'd0, 0, 8'h00, 0, 0, 1);
    if (!SKID) begin
      add(1, 3'd0, 1, 8'h00, 0, 0, 1);
      add(1, 3'd1, 1, 8'h01, 1, 0, 0);
      add(1, 3'd1, 1, 8'h01, 1, 1, 0);
      add(1, 3'd1, 1, 8'h00, 0, 0, 1);
      add(1, 3'd2, 1, 8'h02, 1, 0, 0);
      add(1, 3'd2, 1, 8'h02, 1, 1, 0);
      add(1, 3'd2, 1, 8'h00, 0, 0, 1);
      add(0, 3'd0, 0, 8'h04, 1, 0, 0);
      add(0, 3'd0, 0, 8'h04, 1, 1, 0);
      add(0, 3'd0, 0, 8'h00, 0, 0, 1);
    end else begin
      add(1, 3'd6, 1, 8'h00, 0, 0, 1);
      add(1, 3'd1, 1, 8'h40, 1, 0, 1);
      add(0, 3'd0, 0, 8'h40, 1, 1, 0);
      add(0, 3'd0, 0, 8'h02, 1, 0, 1);
      add(0, 3'd0, 0, 8'h02, 1, 1, 1);
      add(0, 3'd0, 0, 8'h00, 0, 0, 1);
    end

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      i0.in_valid = tbl[k].v; i0.A = tbl[k].a; i0.en = tbl[k].en;
      @(negedge clk);
      chk($sformatf("tbl%0d_y", k), {24'd0, y0}, {24'd0, tbl[k].y});
      chk($sformatf("tbl%0d_busy", k), {31'd0, busy0}, {31'd0, tbl[k].busy});
      chk($sformatf("tbl%0d_done", k), {31'd0, done0}, {31'd0, tbl[k].done});
      chk($sformatf("tbl%0d_rdy", k), {31'd0, i0.in_ready}, {31'd0, tbl[k].rdy});
    end

    // Asynchronous reset in the middle of a strobe.
    @(posedge clk); #1;
    i0.in_valid = 1; i0.A = 3'd7; i0.en = 1;
    @(posedge clk); #1;
    i0.in_valid = 0;
    #2;
    chk("pre_reset_y", {24'd0, y0}, 32'h80);
    reset = 1'b1;
    #1;
    chk("async_reset_y", {24'd0, y0}, 0);
    chk("async_reset_busy", {31'd0, busy0}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    i0.in_valid = 1; i0.A = 3'd3; i0.en = 1;
    @(negedge clk);
    chk("post_reset_rdy", {31'd0, i0.in_ready}, 1);
    @(posedge clk); #1;
    i0.in_valid = 0;
    @(negedge clk);
    chk("post_reset_y", {24'd0, y0}, 32'h08);
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {24'd0, y0}, 0);

    // Silent strobe on the HOLD=3 instance.
    @(posedge clk); #1;
    i1.in_valid = 1; i1.A = 3'd2; i1.en = 0;
    @(negedge clk);
    chk("silent_rdy", {31'd0, i1.in_ready}, 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      i1.in_valid = 0;
      @(negedge clk);
      chk($sformatf("silent%0d_y", k), {24'd0, y1}, 0);
      chk($sformatf("silent%0d_busy", k), {31'd0, busy1}, 1);
      chk($sformatf("silent%0d_done", k), {31'd0, done1}, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("silent_end_busy", {31'd0, busy1}, 0);

    // HOLD=1 sweep on the N=2 instance.
    for (int a = 0; a < 4; a++) begin
      @(posedge clk); #1;
      i2.in_valid = 1; i2.A = 2'(a); i2.en = 1;
      @(negedge clk);
      chk($sformatf("sweep%0d_rdy", a), {31'd0, i2.in_ready}, 1);
      if (SKID && a > 0) begin
        one = 8'd1 << (a - 1);
        chk($sformatf("sweep%0d_prev_y", a), {28'd0, y2}, {24'd0, one});
        chk($sformatf("sweep%0d_prev_done", a), {31'd0, done2}, 1);
      end
      if (!SKID) begin
        @(posedge clk); #1;
        i2.in_valid = 0;
        @(negedge clk);
        one = 8'd1 << a;
        chk($sformatf("sweep%0d_y", a), {28'd0, y2}, {24'd0, one});
        chk($sformatf("sweep%0d_done", a), {31'd0, done2}, 1);
      end
    end
    @(posedge clk); #1;
    i2.in_valid = 0;
    @(negedge clk);
    chk("sweep_tail_y", {28'd0, y2}, SKID ? 32'h8 : 32'h0);
    chk("sweep_tail_done", {31'd0, done2}, SKID ? 1 : 0);
    repeat (2) @(negedge clk);

    // Randomized traffic on the HOLD=2 instance against a strobe schedule.
    last_end   = -1;
    last_start = -1;
    for (c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      i0.in_valid = (($urandom % 10) < 7);
      i0.A        = 3'($urandom % 8);
      i0.en       = (($urandom % 4) != 0);
      @(negedge clk);
      ey = 8'h00; eb = 1'b0; ed = 1'b0;
      foreach (sched[k]) begin
        if (sched[k].s <= c && c <= sched[k].e) begin
          ey = sched[k].y; eb = 1'b1; ed = (c == sched[k].e);
        end
      end
      er = (c > last_end) || (SKID && !(last_start > c));
      chk("rand_y", {24'd0, y0}, {24'd0, ey});
      chk("rand_busy", {31'd0, busy0}, {31'd0, eb});
      chk("rand_done", {31'd0, done0}, {31'd0, ed});
      chk("rand_rdy", {31'd0, i0.in_ready}, {31'd0, er});
      if (i0.in_valid && er) begin
        strobe_t st;
        s = (c + 1 > last_end + 1) ? c + 1 : last_end + 1;
        st.s = s;
        st.e = s + HOLD0 - 1;
        st.y = i0.en ? (8'd1 << i0.A) : 8'd0;
        sched.push_back(st);
        last_start = st.s;
        last_end   = st.e;
      end
      while (sched.size() > 0 && sched[0].e < c) void'(sched.pop_front());
    end

    @(posedge clk); #1;
    i0.in_valid = 0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder.md
Name: onehot_strobe_decoder

Overview:
- Sequential counterpart to the team's binary/one-hot encoders: accepts an N-bit binary index over a valid/ready handshake.
- Drives the matching one-hot line on output Y for a fixed number of clock cycles, then returns Y to zero.
- Used to fire select/strobe lines (mux selects, register-file write enables, row drivers) from a binary address.

Parameters:
- N, 3, index width; Y width is 2**N (N=3 gives 8 outputs, N=2 gives 4).
- HOLD, 2, cycles each one-hot strobe is driven; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  index present on A
- in_ready  output  1  block can accept an index this cycle
- A  input  N  binary index
- en  input  1  sampled with A; 0 means run a silent strobe (Y stays zero, timing unchanged)
- Y  output  2**N  registered one-hot strobe output
- busy  output  1  strobe in progress
- done  output  1  one-cycle pulse in the final strobe cycle

Behaviour:
- Reset (async, active-high):
  - state=IDLE, Y=0, busy=0, done=0, count=0; in_ready=1 once reset deasserts.
  - Reset mid-strobe clears Y immediately (asynchronously); the in-flight index is discarded.
- Handshake:
  - Transfer occurs on a rising edge when in_valid && in_ready.
  - A and en are captured at that edge; A/en are don't-care when in_valid=0.
  - in_valid may drop without a transfer; no obligation on the source.
- FSM states:
  - IDLE: Y=0, busy=0, in_ready=1. On transfer at edge T, go to DRIVE with count=HOLD-1.
  - DRIVE: Y = en_q ? (1 << A_q) : 0; busy=1; in_ready=0 (base build); count decrements each cycle.
  - DRIVE exit: when count==0, done=1 that cycle and the next state is IDLE.
- Latency and timing:
  - Y is valid from cycle T+1 through cycle T+HOLD inclusive.
  - done is asserted in cycle T+HOLD.
  - Y=0 and in_ready=1 in cycle T+HOLD+1.
- Throughput:
  - Base build: at most one index per HOLD+1 cycles (one mandatory IDLE gap).
  - HOLD=1: Y is a single-cycle pulse; done coincides with it.
- Width rules:
  - count width = clog2(HOLD+1).
  - Y is exactly one-hot or all-zero, never multi-hot, including across reset and transitions.
- Out-of-range input: not possible; every N-bit value maps to a line.
- Y, busy and done are all registered outputs, with no combinational path from inputs.
- in_ready is derived from state only (plus buffer flag when the optional feature is built).

Optional Feature:
- Macro: ONEHOT_STROBE_SKID_EN
- Defined: adds a one-entry holding buffer (A_b, en_b, full_b).
  - in_ready = (state==IDLE) || !full_b.
  - A transfer during DRIVE loads the buffer.
  - On the final DRIVE cycle, if full_b is set, the buffer loads into A_q/en_q and DRIVE restarts with count=HOLD-1. Y moves directly to the new line with no zero cycle. done still pulses for the finished strobe.
  - If a transfer occurs on the final DRIVE cycle with the buffer empty, the incoming index loads directly into A_q, giving the same seamless restart.
  - Sustained throughput: one index per HOLD cycles.
- Undefined: buffer logic absent; in_ready=0 throughout DRIVE; base behaviour above.

Decomposition:
- Package onehot_strobe_pkg:
  - state enum {IDLE, DRIVE}
  - HOLD_MAX=255 constant
  - clog2 width function for count
- Sub-module onehot_decoder_comb: purely combinational N-to-2**N decoder with enable, the inverse of the existing encoders.
  - Instantiated once in the datapath before the Y register.
  - Reusable standalone.

Test Plan:
- Reset, then A=3'd5, en=1, in_valid for 1 cycle at edge T, HOLD=2 -> Y=8'b0010_0000 in T+1 and T+2; done=1 in T+2; Y=0, in_ready=1 in T+3.
- Assert reset asynchronously mid-DRIVE (A=3'd7) -> Y=0, busy=0 before the next clock edge; the next index after release behaves normally.
- en=0, A=3'd2, HOLD=3 -> Y stays 0 for 3 cycles; busy=1 for 3 cycles; done pulses in the third cycle.
- Base build, in_valid held high with A=0,1,2 -> transfers spaced HOLD+1 cycles; Y shows 8'h01, 0, 8'h02, 0, 8'h04; never multi-hot.
- ONEHOT_STROBE_SKID_EN, HOLD=2, back-to-back A=6 then A=1 -> Y=8'h40, 8'h40, 8'h02, 8'h02 with no zero cycle between; done pulses after each second cycle.
- N=2, HOLD=1, sweep A=0..3 -> Y=4'b0001, 0, 4'b0010, 0, 4'b0100, 0, 4'b1000; done coincides with each pulse.
